// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between two requesters, with clear sequencing.
// Optional RF_BYPASS_EN forwards the command's own write data to a same-address read.
module regfile_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_done,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_waddr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [AW-1:0] r0_raddr1,
    input  logic [AW-1:0] r0_raddr2,
    output logic          r0_rsp_valid,
    input  logic          r0_rsp_ready,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_waddr,
    input  logic [DW-1:0] r1_wdata,
    input  logic [AW-1:0] r1_raddr1,
    input  logic [AW-1:0] r1_raddr2,
    output logic          r1_rsp_valid,
    input  logic          r1_rsp_ready,
    output logic [DW-1:0] rsp_data1,
    output logic [DW-1:0] rsp_data2,
    output logic          rf_rst,
    output logic          rf_we,
    output logic          rf_mode,
    output logic [AW-1:0] rf_addr_write,
    output logic [DW-1:0] rf_datain,
    output logic [AW-1:0] rf_addr1,
    output logic [AW-1:0] rf_addr2,
    input  logic [DW-1:0] rf_dataout1,
    input  logic [DW-1:0] rf_dataout2
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          owner_q, owner_d;
    logic          cmd_we_q, cmd_we_d;
    logic [AW-1:0] cmd_waddr_q, cmd_waddr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [AW-1:0] cmd_raddr1_q, cmd_raddr1_d;
    logic [AW-1:0] cmd_raddr2_q, cmd_raddr2_d;
    logic [DW-1:0] rsp_data1_q, rsp_data1_d;
    logic [DW-1:0] rsp_data2_q, rsp_data2_d;
    logic          rf_we_q, rf_rst_q, clr_done_q, rsp_valid0_q, rsp_valid1_q;
    logic          gnt0_s, gnt1_s, win_s, any_valid_s, owner_ready_s;

    // Winner is the pointed-to requester if valid, otherwise whichever one is valid.
    assign win_s         = rr_ptr_q ? r1_valid : ~r0_valid;
    assign any_valid_s   = r0_valid | r1_valid;
    assign owner_ready_s = owner_q ? r1_rsp_ready : r0_rsp_ready;

    // Next-state, arbitration and command/response capture.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        cmd_we_d     = cmd_we_q;
        cmd_waddr_d  = cmd_waddr_q;
        cmd_wdata_d  = cmd_wdata_q;
        cmd_raddr1_d = cmd_raddr1_q;
        cmd_raddr2_d = cmd_raddr2_q;
        rsp_data1_d  = rsp_data1_q;
        rsp_data2_d  = rsp_data2_q;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                end else if (any_valid_s) begin
                    gnt0_s       = ~win_s;
                    gnt1_s       = win_s;
                    owner_d      = win_s;
                    cmd_we_d     = win_s ? r1_we     : r0_we;
                    cmd_waddr_d  = win_s ? r1_waddr  : r0_waddr;
                    cmd_wdata_d  = win_s ? r1_wdata  : r0_wdata;
                    cmd_raddr1_d = win_s ? r1_raddr1 : r0_raddr1;
                    cmd_raddr2_d = win_s ? r1_raddr2 : r0_raddr2;
                    state_d      = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: state_d = S_IDLE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
`ifdef RF_BYPASS_EN
                rsp_data1_d = (cmd_we_q && (cmd_raddr1_q == cmd_waddr_q)) ? cmd_wdata_q : rf_dataout1;
                rsp_data2_d = (cmd_we_q && (cmd_raddr2_q == cmd_waddr_q)) ? cmd_wdata_q : rf_dataout2;
`else
                rsp_data1_d = rf_dataout1;
                rsp_data2_d = rf_dataout2;
`endif
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_ready_s) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = ~owner_q;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, command and output registers; strobes are precomputed from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= 1'b0;
            owner_q      <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_waddr_q  <= '0;
            cmd_wdata_q  <= '0;
            cmd_raddr1_q <= '0;
            cmd_raddr2_q <= '0;
            rsp_data1_q  <= '0;
            rsp_data2_q  <= '0;
            rf_we_q      <= 1'b0;
            rf_rst_q     <= 1'b0;
            clr_done_q   <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            cmd_we_q     <= cmd_we_d;
            cmd_waddr_q  <= cmd_waddr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            cmd_raddr1_q <= cmd_raddr1_d;
            cmd_raddr2_q <= cmd_raddr2_d;
            rsp_data1_q  <= rsp_data1_d;
            rsp_data2_q  <= rsp_data2_d;
            rf_we_q      <= (state_d == S_ISSUE) & cmd_we_d;
            rf_rst_q     <= (state_d == S_CLEAR);
            clr_done_q   <= (state_d == S_CLEAR);
            rsp_valid0_q <= (state_d == S_RESP) & ~owner_d;
            rsp_valid1_q <= (state_d == S_RESP) & owner_d;
        end
    end

    assign r0_ready      = gnt0_s & rst;
    assign r1_ready      = gnt1_s & rst;
    assign r0_rsp_valid  = rsp_valid0_q;
    assign r1_rsp_valid  = rsp_valid1_q;
    assign rsp_data1     = rsp_data1_q;
    assign rsp_data2     = rsp_data2_q;
    assign clr_done      = clr_done_q;
    assign rf_rst        = rf_rst_q;
    assign rf_we         = rf_we_q;
    assign rf_mode       = 1'b1;
    assign rf_addr_write = cmd_waddr_q;
    assign rf_datain     = cmd_wdata_q;
    assign rf_addr1      = cmd_raddr1_q;
    assign rf_addr2      = cmd_raddr2_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural read-before-write register file.
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst, clr_req, clr_done;
    logic        r0_valid, r0_ready, r0_we, r0_rsp_valid, r0_rsp_ready;
    logic [4:0]  r0_waddr, r0_raddr1, r0_raddr2;
    logic [31:0] r0_wdata;
    logic        r1_valid, r1_ready, r1_we, r1_rsp_valid, r1_rsp_ready;
    logic [4:0]  r1_waddr, r1_raddr1, r1_raddr2;
    logic [31:0] r1_wdata;
    logic [31:0] rsp_data1, rsp_data2, rf_datain, rf_dataout1, rf_dataout2;
    logic        rf_rst, rf_we, rf_mode;
    logic [4:0]  rf_addr_write, rf_addr1, rf_addr2;
    logic        mdl_clear;
    logic [31:0] mem [0:31];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_done(clr_done),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_waddr(r0_waddr),
        .r0_wdata(r0_wdata), .r0_raddr1(r0_raddr1), .r0_raddr2(r0_raddr2),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_waddr(r1_waddr),
        .r1_wdata(r1_wdata), .r1_raddr1(r1_raddr1), .r1_raddr2(r1_raddr2),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
        .rf_rst(rf_rst), .rf_we(rf_we), .rf_mode(rf_mode), .rf_addr_write(rf_addr_write),
        .rf_datain(rf_datain), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_dataout1(rf_dataout1), .rf_dataout2(rf_dataout2)
    );

    // Register file model: registered reads return pre-write contents.
    always @(posedge clk) begin
        if (rf_rst || mdl_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else if (rf_we) begin
            mem[rf_addr_write] <= rf_datain;
        end
        rf_dataout1 <= (rf_rst || mdl_clear) ? 32'd0 : mem[rf_addr1];
        rf_dataout2 <= (rf_rst || mdl_clear) ? 32'd0 : mem[rf_addr2];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int n, input logic v, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        if (n == 0) begin
            r0_valid = v; r0_we = we; r0_waddr = wa; r0_wdata = wd; r0_raddr1 = a1; r0_raddr2 = a2;
        end else begin
            r1_valid = v; r1_we = we; r1_waddr = wa; r1_wdata = wd; r1_raddr1 = a1; r1_raddr2 = a2;
        end
    endtask

    // Issues one command from requester n and collects the response (bounded waits).
    task automatic run_txn(input int n, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [4:0] a1, input logic [4:0] a2,
                           output bit ok, output int lat, output logic [31:0] d1, output logic [31:0] d2);
        bit acc;
        acc = 1'b0; ok = 1'b0; lat = 0; d1 = 32'd0; d2 = 32'd0;
        set_cmd(n, 1'b1, we, wa, wd, a1, a2);
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = (n == 0) ? r0_ready : r1_ready;
            tick;
        end
        set_cmd(n, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 20 && acc && !ok; i++) begin
            if (((n == 0) ? r0_rsp_valid : r1_rsp_valid) === 1'b1) begin
                ok = 1'b1; lat = i + 1; d1 = rsp_data1; d2 = rsp_data2;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; clr_req = 1'b0; mdl_clear = 1'b1;
        r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
        set_cmd(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        set_cmd(1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick; tick;
        n_vec++;
        if ({r0_ready, r1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b want 00", {r0_ready, r1_ready});
        end
        n_vec++;
        if ({r0_rsp_valid, r1_rsp_valid, rf_we, rf_rst, clr_done} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 00000", {r0_rsp_valid, r1_rsp_valid, rf_we, rf_rst, clr_done});
        end
        n_vec++;
        if ({rsp_data1, rsp_data2} !== 64'd0 || rf_mode !== 1'b1) begin
            n_bad++; $display("FAIL reset_data: got %h %h mode %b want 0 0 mode 1", rsp_data1, rsp_data2, rf_mode);
        end
        set_cmd(0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        set_cmd(1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        mdl_clear = 1'b0;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_same_addr;
        logic [31:0] exp1;
`ifdef RF_BYPASS_EN
        exp1 = 32'hDEADBEEF;
`else
        exp1 = 32'h0000_0000;
`endif
        set_cmd(0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0);
        #1;
        n_vec++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL first_grant: got %b want 10", {r0_ready, r1_ready});
        end
        tick;
        r0_valid = 1'b0;
        n_vec++;
        if ({rf_we, rf_addr_write, rf_datain, rf_addr1, rf_addr2} !== {1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0}) begin
            n_bad++; $display("FAIL issue_drive: got we %b wa %0d wd %h a1 %0d a2 %0d want 1 3 deadbeef 3 0",
                              rf_we, rf_addr_write, rf_datain, rf_addr1, rf_addr2);
        end
        tick;
        n_vec++;
        if ({rf_we, r0_rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL wait_state: got we/valid %b want 00", {rf_we, r0_rsp_valid});
        end
        tick;
        n_vec++;
        if ({r0_rsp_valid, r1_rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL latency3: got %b want 10", {r0_rsp_valid, r1_rsp_valid});
        end
        n_vec++;
        if (rsp_data1 !== exp1 || rsp_data2 !== 32'd0) begin
            n_bad++; $display("FAIL same_addr_read: got %h %h want %h 00000000", rsp_data1, rsp_data2, exp1);
        end
        tick;
        n_vec++;
        if (r0_rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL rsp_drop: got %b want 0", r0_rsp_valid);
        end
    endtask

    task automatic test_write_then_read;
        bit ok; int lat; logic [31:0] d1, d2;
        run_txn(0, 1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, ok, lat, d1, d2);
        n_vec++;
        if (ok !== 1'b1) begin
            n_bad++; $display("FAIL write7_done: got %b want 1", ok);
        end
        run_txn(1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd3, ok, lat, d1, d2);
        n_vec++;
        if (ok !== 1'b1 || lat != 3) begin
            n_bad++; $display("FAIL r1_read_done: got ok %b lat %0d want 1 3", ok, lat);
        end
        n_vec++;
        if (d1 !== 32'h12345678 || d2 !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL r1_read_data: got %h %h want 12345678 deadbeef", d1, d2);
        end
    endtask

    task automatic test_back_to_back;
        int gcyc[$]; int gown[$];
        set_cmd(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        set_cmd(1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        for (int c = 0; c < 16; c++) begin
            #1;
            if (r0_ready === 1'b1) begin gcyc.push_back(c); gown.push_back(0); end
            if (r1_ready === 1'b1) begin gcyc.push_back(c); gown.push_back(1); end
            tick;
        end
        set_cmd(0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        set_cmd(1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        n_vec++;
        if (gown.size() != 4) begin
            n_bad++; $display("FAIL b2b_count: got %0d grants want 4", gown.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (gown[k] != (k % 2) || gcyc[k] != 4 * k) begin
                    n_bad++; $display("FAIL b2b_grant%0d: got r%0d at %0d want r%0d at %0d", k, gown[k], gcyc[k], k % 2, 4 * k);
                end
            end
        end
    endtask

    task automatic test_clear;
        bit ok; int lat; logic [31:0] d1, d2;
        for (int a = 1; a <= 4; a++) begin
            run_txn(0, 1'b1, 5'(a), 32'h11111111 * 32'(a), 5'd0, 5'd0, ok, lat, d1, d2);
        end
        run_txn(1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd4, ok, lat, d1, d2);
        n_vec++;
        if (d1 !== 32'h11111111 || d2 !== 32'h44444444) begin
            n_bad++; $display("FAIL pre_clear_read: got %h %h want 11111111 44444444", d1, d2);
        end
        clr_req = 1'b1;
        set_cmd(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        set_cmd(1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        #1;
        n_vec++;
        if ({r0_ready, r1_ready, rf_rst} !== 3'b000) begin
            n_bad++; $display("FAIL clr_priority: got %b want 000", {r0_ready, r1_ready, rf_rst});
        end
        tick;
        n_vec++;
        if ({rf_rst, clr_done, r0_ready, r1_ready} !== 4'b1100) begin
            n_bad++; $display("FAIL clear_cycle: got %b want 1100", {rf_rst, clr_done, r0_ready, r1_ready});
        end
        clr_req = 1'b0;
        tick;
        n_vec++;
        if ({rf_rst, clr_done} !== 2'b00) begin
            n_bad++; $display("FAIL clear_one_cycle: got %b want 00", {rf_rst, clr_done});
        end
        run_txn(0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, ok, lat, d1, d2);
        n_vec++;
        if (ok !== 1'b1 || {d1, d2} !== 64'd0) begin
            n_bad++; $display("FAIL post_clear_r0: got ok %b %h %h want 1 0 0", ok, d1, d2);
        end
        run_txn(1, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, ok, lat, d1, d2);
        n_vec++;
        if (ok !== 1'b1 || {d1, d2} !== 64'd0) begin
            n_bad++; $display("FAIL post_clear_r1: got ok %b %h %h want 1 0 0", ok, d1, d2);
        end
    endtask

    task automatic test_stall;
        bit ok; int lat; logic [31:0] d1, d2;
        run_txn(0, 1'b1, 5'd5, 32'hA5A5A5A5, 5'd0, 5'd0, ok, lat, d1, d2);
        r1_rsp_ready = 1'b0;
        set_cmd(1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd3);
        set_cmd(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
        #1;
        n_vec++;
        if ({r0_ready, r1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL stall_grant: got %b want 01", {r0_ready, r1_ready});
        end
        tick;
        r1_valid = 1'b0;
        tick; tick;
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if ({r1_rsp_valid, r0_rsp_valid, r0_ready} !== 3'b100 || rsp_data1 !== 32'hA5A5A5A5 || rsp_data2 !== 32'd0) begin
                n_bad++; $display("FAIL stall_hold%0d: got v %b d %h %h want 100 a5a5a5a5 0",
                                  c, {r1_rsp_valid, r0_rsp_valid, r0_ready}, rsp_data1, rsp_data2);
            end
            tick;
        end
        r1_rsp_ready = 1'b1;
        tick;
        n_vec++;
        if ({r0_ready, r1_rsp_valid} !== 2'b10) begin
            n_bad++; $display("FAIL stall_release: got %b want 10", {r0_ready, r1_rsp_valid});
        end
        tick;
        r0_valid = 1'b0;
        tick; tick;
        n_vec++;
        if (r0_rsp_valid !== 1'b1) begin
            n_bad++; $display("FAIL post_stall_rsp: got %b want 1", r0_rsp_valid);
        end
        tick;
    endtask

    task automatic test_reset_mid;
        set_cmd(1, 1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 5'd5, 5'd0);
        #1;
        n_vec++;
        if ({r0_ready, r1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL mid_grant: got %b want 01", {r0_ready, r1_ready});
        end
        tick;
        r1_valid = 1'b0;
        tick;
        r0_valid = 1'b1;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rf_we, rf_rst, clr_done} !== 7'b0) begin
            n_bad++; $display("FAIL mid_reset_ctrl: got %b want 0000000",
                              {r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, rf_we, rf_rst, clr_done});
        end
        n_vec++;
        if ({rsp_data1, rsp_data2, rf_datain} !== 96'd0 || {rf_addr1, rf_addr2, rf_addr_write} !== 15'd0) begin
            n_bad++; $display("FAIL mid_reset_data: got %h %h %h a %0d %0d %0d want all 0",
                              rsp_data1, rsp_data2, rf_datain, rf_addr1, rf_addr2, rf_addr_write);
        end
        tick;
        r0_valid = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            n_vec++;
            if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin
                n_bad++; $display("FAIL no_rsp_after_reset%0d: got %b want 00", c, {r0_rsp_valid, r1_rsp_valid});
            end
        end
        set_cmd(0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        set_cmd(1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        n_vec++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL rr_after_reset: got %b want 10", {r0_ready, r1_ready});
        end
        tick;
        set_cmd(0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        set_cmd(1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        tick; tick; tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_same_addr;
        test_write_then_read;
        test_back_to_back;
        test_clear;
        test_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
